board_cover_flood: RTL and testbench

Parametrised successor to the 16×16 cover-state store. Holds per-cell cover state (covered / opened / flagged) for an X_SIZE×Y_SIZE board and accepts open and flag commands over a valid/ready handshake. Adds automatic flood-opening of zero-count regions, flag and opened-cell counters, loss and win detection, and a registered display read port. It sits between the input controller, the mine-map block (through the lookup port) and the VGA renderer.

---
 rtl/minesweeper_pkg.sv | 23 ++
 rtl/neighbor_zero_check.sv | 36 +++
 rtl/board_cover_flood.sv | 191 +++++++++++++++++++
 tb/tb_board_cover_flood.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper blocks: cover-state encoding,
// command op codes and the cover-store FSM states.
package minesweeper_pkg;

    localparam logic [1:0] COVER_COVERED = 2'b00;
    localparam logic [1:0] COVER_OPENED  = 2'b01;
    localparam logic [1:0] COVER_FLAGGED = 2'b10;

    localparam logic [1:0] OP_OPEN = 2'b01;
    localparam logic [1:0] OP_FLAG = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    // The reserved code 11 behaves exactly like a covered cell.
    function automatic logic is_covered(input logic [1:0] s);
        return (s == COVER_COVERED) || (s == 2'b11);
    endfunction

endpackage

// File: rtl/neighbor_zero_check.sv
// Combinational test: does any in-board neighbour of (x_i, y_i) hold an
// opened cell whose zero bit is set. Coordinates never wrap at the edges.
module neighbor_zero_check
    import minesweeper_pkg::*;
#(
    parameter int X_SIZE = 16,
    parameter int Y_SIZE = 16,
    parameter int X_BITS = 4,
    parameter int Y_BITS = 4
) (
    input  logic [2*X_SIZE*Y_SIZE-1:0] state_i,
    input  logic [X_SIZE*Y_SIZE-1:0]   zero_i,
    input  logic [X_BITS-1:0]          x_i,
    input  logic [Y_BITS-1:0]          y_i,
    output logic                       hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int nx;
                int ny;
                int ni;
                nx = int'(x_i) + dx;
                ny = int'(y_i) + dy;
                ni = ny * X_SIZE + nx;
                if ((dx != 0 || dy != 0) && nx >= 0 && nx < X_SIZE && ny >= 0 && ny < Y_SIZE) begin
                    if (state_i[2*ni +: 2] == COVER_OPENED && zero_i[ni])
                        hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_cover_flood.sv
// Per-cell cover store with open/flag commands, row-major flood-open sweeps
// of zero-count regions, flag/opened counters and win/loss tracking.
module board_cover_flood
    import minesweeper_pkg::*;
#(
    parameter int X_SIZE     = 16,
    parameter int Y_SIZE     = 16,
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 4,
    parameter int MINE_COUNT = 40,
    parameter int CNT_BITS   = 9,
    parameter int FLOOD_EN   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [X_BITS-1:0]   cmd_x,
    input  logic [Y_BITS-1:0]   cmd_y,
    output logic [X_BITS-1:0]   look_x,
    output logic [Y_BITS-1:0]   look_y,
    input  logic                look_mine,
    input  logic [3:0]          look_count,
    input  logic [X_BITS-1:0]   rd_x,
    input  logic [Y_BITS-1:0]   rd_y,
    output logic [1:0]          rd_val,
    output logic                opened_pulse,
    output logic [CNT_BITS-1:0] flags_cnt,
    output logic [CNT_BITS-1:0] opened_cnt,
    output logic                busy,
    output logic                lost,
    output logic                won,
    output logic [1:0]          dbg_state
);

    localparam int                  N       = X_SIZE * Y_SIZE;
    localparam logic [CNT_BITS-1:0] WIN_CNT = CNT_BITS'(N - MINE_COUNT);
    localparam logic [X_BITS-1:0]   X_LAST  = X_BITS'(X_SIZE - 1);
    localparam logic [Y_BITS-1:0]   Y_LAST  = Y_BITS'(Y_SIZE - 1);

    state_e              state_q, state_d;
    logic [X_BITS-1:0]   sx_q, sx_d, sx_nx;
    logic [Y_BITS-1:0]   sy_q, sy_d, sy_nx;
    logic                changed_q, changed_d;
    logic [2*N-1:0]      cells_q, cells_d;
    logic [N-1:0]        zero_q, zero_d;
    logic [CNT_BITS-1:0] flags_q, flags_d, opened_q, opened_d;
    logic                lost_q, lost_d, won_q, won_d, pulse_q, pulse_d;
    logic [1:0]          rd_val_q;

    logic       scan_last, nbr_zero, cmd_in_range, rd_in_range, accept;
    int         scan_idx, cmd_idx, rd_idx;
    logic [1:0] scan_cell, cmd_cell, rd_cell;

    neighbor_zero_check #(
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .X_BITS(X_BITS), .Y_BITS(Y_BITS)
    ) u_nbr (
        .state_i(cells_q), .zero_i(zero_q), .x_i(sx_q), .y_i(sy_q), .hit_o(nbr_zero)
    );

    always_comb begin
        scan_idx     = int'(sy_q) * X_SIZE + int'(sx_q);
        cmd_in_range = (int'(cmd_x) < X_SIZE) && (int'(cmd_y) < Y_SIZE);
        cmd_idx      = cmd_in_range ? int'(cmd_y) * X_SIZE + int'(cmd_x) : 0;
        rd_in_range  = (int'(rd_x) < X_SIZE) && (int'(rd_y) < Y_SIZE);
        rd_idx       = rd_in_range ? int'(rd_y) * X_SIZE + int'(rd_x) : 0;
        scan_cell    = cells_q[2*scan_idx +: 2];
        cmd_cell     = cells_q[2*cmd_idx +: 2];
        rd_cell      = cells_q[2*rd_idx +: 2];
        scan_last    = (sx_q == X_LAST) && (sy_q == Y_LAST);
        sx_nx        = (sx_q == X_LAST) ? '0 : sx_q + 1'b1;
        sy_nx        = (sx_q != X_LAST) ? sy_q : (scan_last ? '0 : sy_q + 1'b1);
    end

    // Handshake: a command transfers on every edge where cmd_valid && cmd_ready.
    // cmd_ready depends only on internal state, never on cmd_valid.
    assign cmd_ready = (state_q == ST_IDLE) && !lost_q && !won_q;
    assign accept    = cmd_valid && cmd_ready;
    assign look_x    = (state_q == ST_IDLE) ? cmd_x : sx_q;
    assign look_y    = (state_q == ST_IDLE) ? cmd_y : sy_q;

    always_comb begin
        state_d   = state_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        changed_d = changed_q;
        cells_d   = cells_q;
        zero_d    = zero_q;
        flags_d   = flags_q;
        opened_d  = opened_q;
        lost_d    = lost_q;
        pulse_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                cells_d[2*scan_idx +: 2] = COVER_COVERED;
                zero_d[scan_idx]         = 1'b0;
                sx_d = sx_nx;
                sy_d = sy_nx;
                if (scan_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept && cmd_in_range) begin
                    if (cmd_op == OP_OPEN && is_covered(cmd_cell)) begin
                        cells_d[2*cmd_idx +: 2] = COVER_OPENED;
                        zero_d[cmd_idx]         = !look_mine && (look_count == 4'd0);
                        pulse_d  = 1'b1;
                        opened_d = opened_q + 1'b1;
                        if (look_mine) begin
                            lost_d = 1'b1;
                        end else if (FLOOD_EN != 0 && look_count == 4'd0) begin
                            state_d   = ST_SWEEP;
                            sx_d      = '0;
                            sy_d      = '0;
                            changed_d = 1'b0;
                        end
                    end else if (cmd_op == OP_FLAG) begin
                        if (is_covered(cmd_cell)) begin
                            cells_d[2*cmd_idx +: 2] = COVER_FLAGGED;
                            flags_d = flags_q + 1'b1;
                        end else if (cmd_cell == COVER_FLAGGED) begin
                            cells_d[2*cmd_idx +: 2] = COVER_COVERED;
                            flags_d = flags_q - 1'b1;
                        end
                    end
                end
            end
            ST_SWEEP: begin
                if (is_covered(scan_cell) && !look_mine && nbr_zero) begin
                    cells_d[2*scan_idx +: 2] = COVER_OPENED;
                    zero_d[scan_idx]         = (look_count == 4'd0);
                    pulse_d   = 1'b1;
                    opened_d  = opened_q + 1'b1;
                    changed_d = 1'b1;
                end
                sx_d = sx_nx;
                sy_d = sy_nx;
                // A pass that opened anything may have exposed new zero cells behind the scan.
                if (scan_last) begin
                    if (changed_d) changed_d = 1'b0;
                    else           state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        won_d = won_q || (!lost_d && opened_d == WIN_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            sx_q      <= '0;
            sy_q      <= '0;
            changed_q <= 1'b0;
            flags_q   <= '0;
            opened_q  <= '0;
            lost_q    <= 1'b0;
            won_q     <= 1'b0;
            pulse_q   <= 1'b0;
            rd_val_q  <= COVER_COVERED;
        end else begin
            state_q   <= state_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            changed_q <= changed_d;
            flags_q   <= flags_d;
            opened_q  <= opened_d;
            lost_q    <= lost_d;
            won_q     <= won_d;
            pulse_q   <= pulse_d;
            rd_val_q  <= (state_q == ST_INIT || !rd_in_range || is_covered(rd_cell))
                         ? COVER_COVERED : rd_cell;
        end
    end

    // Cell storage needs no reset: INIT rewrites every cell before IDLE.
    always_ff @(posedge clk) begin
        cells_q <= cells_d;
        zero_q  <= zero_d;
    end

    assign rd_val       = rd_val_q;
    assign opened_pulse = pulse_q;
    assign flags_cnt    = flags_q;
    assign opened_cnt   = opened_q;
    assign busy         = (state_q != ST_IDLE);
    assign lost         = lost_q;
    assign won          = won_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_board_cover_flood.sv
// Directed bench for board_cover_flood: one flooding instance (single mine,
// win reachable) and one FLOOD_EN=0 instance sharing the command/read inputs.
module tb_board_cover_flood;
    import minesweeper_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_x, cmd_y, rd_x, rd_y;

    logic       ready_a, look_mine_a, pulse_a, busy_a, lost_a, won_a;
    logic [3:0] look_x_a, look_y_a, look_count_a;
    logic [1:0] rd_val_a, dbg_a;
    logic [8:0] flags_a, opened_a;

    logic       ready_b, look_mine_b, pulse_b, busy_b, lost_b, won_b;
    logic [3:0] look_x_b, look_y_b, look_count_b;
    logic [1:0] rd_val_b, dbg_b;
    logic [8:0] flags_b, opened_b;

    logic       mine_map [16][16];
    logic [3:0] cnt_map  [16][16];

    int n_total = 0;
    int n_bad   = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    board_cover_flood #(.MINE_COUNT(1), .FLOOD_EN(1)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .look_x(look_x_a), .look_y(look_y_a), .look_mine(look_mine_a), .look_count(look_count_a),
        .rd_x(rd_x), .rd_y(rd_y), .rd_val(rd_val_a), .opened_pulse(pulse_a),
        .flags_cnt(flags_a), .opened_cnt(opened_a), .busy(busy_a),
        .lost(lost_a), .won(won_a), .dbg_state(dbg_a)
    );

    board_cover_flood #(.FLOOD_EN(0)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .look_x(look_x_b), .look_y(look_y_b), .look_mine(look_mine_b), .look_count(look_count_b),
        .rd_x(rd_x), .rd_y(rd_y), .rd_val(rd_val_b), .opened_pulse(pulse_b),
        .flags_cnt(flags_b), .opened_cnt(opened_b), .busy(busy_b),
        .lost(lost_b), .won(won_b), .dbg_state(dbg_b)
    );

    assign look_mine_a  = mine_map[look_y_a][look_x_a];
    assign look_count_a = cnt_map[look_y_a][look_x_a];
    assign look_mine_b  = mine_map[look_y_b][look_x_b];
    assign look_count_b = cnt_map[look_y_b][look_x_b];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pulse_a) pulses_a <= pulses_a + 1;
        if (pulse_b) pulses_b <= pulses_b + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_single_mine(input int mx, input int my);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                mine_map[y][x] = 1'b0;
        mine_map[my][mx] = 1'b1;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                int c;
                c = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 16 &&
                            y + dy >= 0 && y + dy < 16 && mine_map[y+dy][x+dx])
                            c++;
                cnt_map[y][x] = 4'(c);
            end
        end
    endtask

    // driver tasks: all called and returning on a negedge
    task automatic do_reset();
        int n;
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_ready",  ready_a,  0);
        check("rst_rd_val", rd_val_a, 0);
        check("rst_flags",  flags_a,  0);
        check("rst_opened", opened_a, 0);
        check("rst_lost",   lost_a,   0);
        check("rst_won",    won_a,    0);
        check("rst_pulse",  pulse_a,  0);
        reset = 1'b0;
        n = 0;
        while (busy_a && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", n, 256);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int x, input int y, input bit on_b);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_y     = 4'(y);
        cmd_valid = 1'b1;
        while (!(on_b ? ready_b : ready_a) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("cmd_accepted", (n < 2000), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic hold_cmd(input logic [1:0] op, input int x, input int y, input int cycles);
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_y     = 4'(y);
        cmd_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic read_cell(input int x, input int y, output logic [1:0] va, output logic [1:0] vb);
        rd_x = 4'(x);
        rd_y = 4'(y);
        @(negedge clk);
        va = rd_val_a;
        vb = rd_val_b;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("flood_done", (n < 5000), 1);
    endtask

    initial begin
        logic [1:0] va, vb;
        int nz, base;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_x = '0; cmd_y = '0; rd_x = '0; rd_y = '0;

        // after INIT: all covered, ready, counters clear
        load_single_mine(5, 5);
        do_reset();
        check("idle_ready",  ready_a,  1);
        check("idle_flags",  flags_a,  0);
        check("idle_opened", opened_a, 0);
        nz = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                read_cell(x, y, va, vb);
                if (va != 2'b00) nz++;
            end
        check("init_all_covered", nz, 0);

        // flag toggle and open-on-flagged
        send_cmd(OP_FLAG, 3, 4, 0);
        check("flag1_cnt", flags_a, 1);
        read_cell(3, 4, va, vb);
        check("flag1_rd", va, 2);
        send_cmd(OP_FLAG, 3, 4, 0);
        check("flag2_cnt", flags_a, 0);
        read_cell(3, 4, va, vb);
        check("flag2_rd", va, 0);
        send_cmd(OP_FLAG, 3, 4, 0);
        send_cmd(OP_OPEN, 3, 4, 0);
        check("open_flagged_pulse",  pulse_a,  0);
        check("open_flagged_opened", opened_a, 0);
        read_cell(3, 4, va, vb);
        check("open_flagged_rd", va, 2);

        // open a mine: loss, then commands refused
        send_cmd(OP_OPEN, 5, 5, 0);
        check("mine_pulse",  pulse_a,  1);
        check("mine_opened", opened_a, 1);
        check("mine_lost",   lost_a,   1);
        check("mine_ready",  ready_a,  0);
        read_cell(5, 5, va, vb);
        check("mine_rd", va, 1);
        hold_cmd(OP_OPEN, 0, 0, 10);
        check("lost_ignore_opened", opened_a, 1);
        check("lost_ignore_busy",   busy_a,   0);
        check("lost_flags",         flags_a,  1);
        read_cell(0, 0, va, vb);
        check("lost_ignore_rd", va, 0);

        // full flood with a single mine in the corner: win
        load_single_mine(15, 15);
        do_reset();
        base = pulses_a;
        send_cmd(OP_OPEN, 0, 0, 0);
        wait_idle_a();
        check("win_pulses", pulses_a - base, 255);
        check("win_opened", opened_a, 255);
        check("win_won",    won_a,    1);
        check("win_lost",   lost_a,   0);
        check("win_ready",  ready_a,  0);
        read_cell(15, 15, va, vb);
        check("win_mine_rd", va, 0);
        read_cell(14, 14, va, vb);
        check("win_edge_rd", va, 1);
        read_cell(15, 0, va, vb);
        check("win_corner_rd", va, 1);

        // flood around a flagged cell
        do_reset();
        send_cmd(OP_FLAG, 2, 2, 0);
        base = pulses_a;
        send_cmd(OP_OPEN, 0, 0, 0);
        wait_idle_a();
        check("fl_pulses", pulses_a - base, 254);
        check("fl_opened", opened_a, 254);
        check("fl_flags",  flags_a,  1);
        check("fl_won",    won_a,    0);
        check("fl_ready",  ready_a,  1);
        read_cell(2, 2, va, vb);
        check("fl_flag_rd", va, 2);
        read_cell(3, 3, va, vb);
        check("fl_nbr_rd", va, 1);
        send_cmd(OP_OPEN, 0, 0, 0);
        check("reopen_pulse",  pulse_a,  0);
        check("reopen_opened", opened_a, 254);
        send_cmd(OP_FLAG, 1, 1, 0);
        check("flag_opened_cnt", flags_a, 1);
        read_cell(1, 1, va, vb);
        check("flag_opened_rd", va, 1);

        // reset in the middle of a sweep
        do_reset();
        send_cmd(OP_OPEN, 0, 0, 0);
        repeat (40) @(negedge clk);
        check("mid_busy",  busy_a, 1);
        check("mid_state", dbg_a,  2);
        do_reset();

        // no-flood instance opens only the addressed cell
        base = pulses_b;
        send_cmd(OP_OPEN, 0, 0, 1);
        check("nf_pulse", pulse_b, 1);
        repeat (600) @(negedge clk);
        check("nf_pulses", pulses_b - base, 1);
        check("nf_opened", opened_b, 1);
        check("nf_busy",   busy_b,   0);
        read_cell(0, 0, va, vb);
        check("nf_rd_cell", vb, 1);
        read_cell(1, 0, va, vb);
        check("nf_rd_nbr", vb, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
